// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// memory-access FSM states and the EX-stage forwarding select encodings.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// Operand forwarding select for one EX-stage source register.
// The MEM-stage result is younger than WB, so it wins; x0 is never forwarded.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic [1:0] mem_regwrite,
    input  logic [1:0] mem_memread,
    input  logic [4:0] wb_rd,
    input  logic [1:0] wb_regwrite,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        // A load in MEM has no ALU result yet; load-use stalling covers that case.
        if ((mem_regwrite != 2'b00) && (mem_memread == 2'b00) &&
            (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
            fwd = FWD_MEM;
        end else if ((wb_regwrite != 2'b00) && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: pipeline stall/flush/PC-write priority, forwarding
// selects, data-memory wait/timeout FSM and saturating performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic [1:0]       ex_memread,
    input  logic [1:0]       ex_regwrite,
    input  logic             branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_memread,
    input  logic [1:0]       mem_memwrite,
    input  logic [1:0]       mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic [1:0]       wb_regwrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             ex_mem_flush,
    output logic             mem_wb_stall,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);

    hz_state_e        state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] lu_stall_cnt_q, lu_stall_cnt_d;
    logic [CNT_W-1:0] mem_stall_cnt_q, mem_stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       macc, mem_hold, load_use;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    // EX never forwards its own result (MEM/WB cover it), so ex_regwrite has no consumer here.
    logic unused_ex_regwrite;
    assign unused_ex_regwrite = ^ex_regwrite;

    forward_unit u_fwd_a (
        .ex_rs        (ex_rs1),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memread  (mem_memread),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_a_raw)
    );

    forward_unit u_fwd_b (
        .ex_rs        (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memread  (mem_memread),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_b_raw)
    );

    always_comb begin
        macc     = (mem_memread != 2'b00) || (mem_memwrite != 2'b00);
        mem_hold = (macc && !dmem_ready) || (state_q == ERR);
        load_use = (ex_memread != 2'b00) && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

        dmem_req     = rst && macc && (state_q != ERR);
        pc_write     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_stall = 1'b0;
        mem_wb_flush = 1'b0;
        fwd_a        = rst ? fwd_a_raw : FWD_RF;
        fwd_b        = rst ? fwd_b_raw : FWD_RF;

        lu_stall_cnt_d  = lu_stall_cnt_q;
        mem_stall_cnt_d = mem_stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;

        if (rst) begin
            if (mem_hold) begin
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
                if (~&mem_stall_cnt_q) mem_stall_cnt_d = mem_stall_cnt_q + CNT_W'(1);
            end else if (branch_taken) begin
                pc_write    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (~&flush_cnt_q) flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else if (load_use) begin
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
                if (~&lu_stall_cnt_q) lu_stall_cnt_d = lu_stall_cnt_q + CNT_W'(1);
            end else begin
                pc_write = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            RUN: begin
                if (macc && !dmem_ready) begin
                    state_d    = WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_q == WCW'(MEM_TIMEOUT)) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= RUN;
            wait_cnt_q      <= '0;
            mem_err_q       <= 1'b0;
            lu_stall_cnt_q  <= '0;
            mem_stall_cnt_q <= '0;
            flush_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            mem_err_q       <= mem_err_d;
            lu_stall_cnt_q  <= lu_stall_cnt_d;
            mem_stall_cnt_q <= mem_stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign mem_err       = mem_err_q;
    assign lu_stall_cnt  = lu_stall_cnt_q;
    assign mem_stall_cnt = mem_stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule
